// File: rtl/dmem_waitstate_ctrl.sv
// dmem_waitstate_ctrl: MEM-stage data RAM with request/response handshake,
// configurable wait states, RV32 byte/half/word access and error flags.
//
// Ports:
//   clk, rstn               clock, async active-low reset
//   req_valid/req_ready     request handshake (ready low = pipeline stall)
//   req_we, req_funct3      store flag, RISC-V funct3 width/extension
//   req_addr, req_wdata     byte address, store operand (low bits)
//   resp_valid              one-cycle completion pulse
//   resp_rdata              extended load data (0 for stores/errors)
//   resp_misalign, resp_oob error flags, held until the next response
//
// Build option: define DMEM_INIT_CLEAR_EN to zero the whole array after
// reset (INIT state, one word per cycle, req_ready low meanwhile).
module dmem_waitstate_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_oob
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WC      = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    INIT = 2'd3
  } state_t;
  localparam state_t RST_STATE = INIT;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  logic [31:0] mem [DEPTH];

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic          r_we;
  logic [2:0]    r_f3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic          accept;
  logic          f3_bad;
  logic          is_h;
  logic          is_w;
  logic          in_mis;
  logic          in_oob;

  logic          cur_we;
  logic [2:0]    cur_f3;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_mis;
  logic          cur_oob;
  logic [AW-1:0] cur_idx;

  logic          enter_resp;
  logic          do_wr;
  logic [3:0]    wmask;
  logic [31:0]   wlane;

  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;
  logic [31:0]   rdata_next;

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0] init_idx;
  logic          init_we;
`endif

  assign req_ready  = (state == IDLE) | (state == RESP);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;

  // Error decode on the incoming request.
  always_comb begin
    f3_bad = 1'b0;
    is_h   = 1'b0;
    is_w   = 1'b0;
    unique case (req_funct3)
      3'b000: f3_bad = 1'b0;
      3'b001: is_h = 1'b1;
      3'b010: is_w = 1'b1;
      3'b100: f3_bad = req_we;
      3'b101: begin
        f3_bad = req_we;
        is_h   = 1'b1;
      end
      default: f3_bad = 1'b1;
    endcase
  end

  assign in_mis = f3_bad
                | (is_h & req_addr[0])
                | (is_w & (|req_addr[1:0]));

  // Misalign wins; oob only reported for aligned accesses.
  assign in_oob = ~in_mis
                & ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // The access completing on this edge: the incoming request when it goes
  // straight to RESP, otherwise the one registered at accept.
  assign cur_we    = accept ? req_we             : r_we;
  assign cur_f3    = accept ? req_funct3         : r_f3;
  assign cur_addr  = accept ? req_addr[AW+1:0]   : r_addr;
  assign cur_wdata = accept ? req_wdata          : r_wdata;
  assign cur_mis   = accept & in_mis;
  assign cur_oob   = accept & in_oob;
  assign cur_idx   = cur_addr[AW+1:2];

  // Next state and wait counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (accept) begin
          if (in_mis | in_oob | NO_WAIT) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WC;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
`ifdef DMEM_INIT_CLEAR_EN
      INIT: begin
        if (init_idx == {AW{1'b1}}) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Only IDLE/RESP can accept, and WAIT only leaves to RESP, so any
  // transition into RESP is a completing access.
  assign enter_resp = (state_next == RESP);

  // rstn gate keeps a request seen while reset is held out of the array.
  assign do_wr = rstn & enter_resp & cur_we
               & ~cur_mis & ~cur_oob;

  always_comb begin
    wmask = 4'b0000;
    wlane = 32'h0;
    unique case (cur_f3[1:0])
      2'b00: begin
        wmask = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wmask = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wlane = cur_wdata;
      end
    endcase
  end

`ifdef DMEM_INIT_CLEAR_EN
  assign init_we = rstn & (state == INIT);
`endif

  // Array is never reset; only written by stores and the optional clear.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[cur_idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
`ifdef DMEM_INIT_CLEAR_EN
    if (init_we) begin
      mem[init_idx] <= '0;
    end
`endif
  end

  // Load path: read before this edge's write, so a store-then-load pair
  // sees the store because the store committed on an earlier edge.
  assign rword = mem[cur_idx];
  assign rbyte = rword[{cur_addr[1:0], 3'b000} +: 8];
  assign rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rext = rword;
    unique case (cur_f3)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b100:  rext = {24'h0, rbyte};
      3'b101:  rext = {16'h0, rhalf};
      default: rext = rword;
    endcase
  end

  assign rdata_next = (cur_we | cur_mis | cur_oob)
                    ? 32'h0 : rext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_STATE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if (accept) begin
      r_we    <= req_we;
      r_f3    <= req_funct3;
      r_addr  <= req_addr[AW+1:0];
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_rdata    <= 32'h0;
      resp_misalign <= 1'b0;
      resp_oob      <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata    <= rdata_next;
      resp_misalign <= cur_mis;
      resp_oob      <= cur_oob;
    end
  end

`ifdef DMEM_INIT_CLEAR_EN
  // Restarts from word 0 on every reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_idx <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_waitstate_ctrl.sv
// tb_dmem_waitstate_ctrl: directed bench for dmem_waitstate_ctrl.
// Instance a: WAIT_CYCLES=2, instance z: WAIT_CYCLES=0, both DEPTH=16.
module tb_dmem_waitstate_ctrl;

  logic clk;
  logic rstn;

  logic        a_valid, a_we, a_ready, a_rv, a_mis, a_oob;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, a_rdata;

  logic        z_valid, z_we, z_ready, z_rv, z_mis, z_oob;
  logic [2:0]  z_f3;
  logic [31:0] z_addr, z_wdata, z_rdata;

  int n_chk;
  int n_fail;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

`ifdef DMEM_INIT_CLEAR_EN
  localparam int INIT_CYC = 16;
  localparam logic RST_RDY = 1'b0;
`else
  localparam int INIT_CYC = 0;
  localparam logic RST_RDY = 1'b1;
`endif

  dmem_waitstate_ctrl #(.DEPTH(16), .WAIT_CYCLES(2)) u_a (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (a_valid),
    .req_we        (a_we),
    .req_funct3    (a_f3),
    .req_addr      (a_addr),
    .req_wdata     (a_wdata),
    .req_ready     (a_ready),
    .resp_valid    (a_rv),
    .resp_rdata    (a_rdata),
    .resp_misalign (a_mis),
    .resp_oob      (a_oob)
  );

  dmem_waitstate_ctrl #(.DEPTH(16), .WAIT_CYCLES(0)) u_z (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (z_valid),
    .req_we        (z_we),
    .req_funct3    (z_f3),
    .req_addr      (z_addr),
    .req_wdata     (z_wdata),
    .req_ready     (z_ready),
    .resp_valid    (z_rv),
    .resp_rdata    (z_rdata),
    .resp_misalign (z_mis),
    .resp_oob      (z_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on instance a; inputs are scrambled right after accept.
  task automatic acc(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        mis,
    output logic        oob,
    output int          lat,
    output int          nrdy
  );
    int k;
    k = 0;
    @(negedge clk);
    while (!a_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!a_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL acc_ready_timeout got=%b want=1", a_ready);
    end
    a_valid = 1'b1;
    a_we    = we;
    a_f3    = f3;
    a_addr  = addr;
    a_wdata = wd;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_we    = ~we;
    a_f3    = 3'b010;
    a_addr  = 32'hFFFF_FFFC;
    a_wdata = 32'hA5A5_A5A5;
    lat  = 0;
    nrdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!a_ready) nrdy++;
    end while (!a_rv && lat < 40);
    rd  = a_rdata;
    mis = a_mis;
    oob = a_oob;
  endtask

  task automatic test_reset();
    int k;
    rstn = 1'b0;
    a_valid = 0; a_we = 0; a_f3 = 0; a_addr = 0; a_wdata = 0;
    z_valid = 0; z_we = 0; z_f3 = 0; z_addr = 0; z_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (a_rv !== 1'b0) begin
      n_fail++; $display("FAIL rst_rv got=%b want=0", a_rv);
    end
    n_chk++;
    if (a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata got=%h want=0", a_rdata);
    end
    n_chk++;
    if ({a_mis, a_oob} !== 2'b00) begin
      n_fail++; $display("FAIL rst_flags got=%b want=00", {a_mis, a_oob});
    end
    n_chk++;
    if (a_ready !== RST_RDY) begin
      n_fail++; $display("FAIL rst_ready got=%b want=%b", a_ready, RST_RDY);
    end
    n_chk++;
    if ({z_rv, z_mis, z_oob} !== 3'b000) begin
      n_fail++; $display("FAIL rst_z_flags got=%b want=000", {z_rv, z_mis, z_oob});
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    k = 0;
    while (!a_ready && k < 100) begin
      k++;
      @(negedge clk);
      #1;
    end
    n_chk++;
    if (k !== INIT_CYC) begin
      n_fail++; $display("FAIL rst_ready_low_cycles got=%0d want=%0d", k, INIT_CYC);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic mis, oob;
    int lat, nrdy;
    acc(1'b1, F_W, 32'h10, 32'hDEAD_BEEF, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (lat !== 3 || nrdy !== 2) begin
      n_fail++; $display("FAIL sw_latency got=%0d/%0d want=3/2", lat, nrdy);
    end
    n_chk++;
    if ({rd, mis, oob} !== {32'h0, 2'b00}) begin
      n_fail++; $display("FAIL sw_resp got=%h %b%b want=0 00", rd, mis, oob);
    end
    acc(1'b0, F_W, 32'h10, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (lat !== 3 || nrdy !== 2) begin
      n_fail++; $display("FAIL lw_latency got=%0d/%0d want=3/2", lat, nrdy);
    end
    n_chk++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw_data got=%h want=deadbeef", rd);
    end
    @(negedge clk);
    n_chk++;
    if (a_rv !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL resp_hold got=%b %h want=0 deadbeef", a_rv, a_rdata);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    logic mis, oob;
    int lat, nrdy;
    acc(1'b1, F_W, 32'h20, 32'h80FF_7F01, rd, mis, oob, lat, nrdy);
    acc(1'b0, F_B, 32'h23, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb got=%h want=ffffff80", rd);
    end
    acc(1'b0, F_BU, 32'h23, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu got=%h want=00000080", rd);
    end
    acc(1'b0, F_H, 32'h22, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'hFFFF_80FF) begin
      n_fail++; $display("FAIL lh got=%h want=ffff80ff", rd);
    end
    acc(1'b0, F_HU, 32'h22, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h0000_80FF) begin
      n_fail++; $display("FAIL lhu got=%h want=000080ff", rd);
    end
    acc(1'b0, F_B, 32'h21, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h0000_007F) begin
      n_fail++; $display("FAIL lb_pos got=%h want=0000007f", rd);
    end
    acc(1'b1, F_B, 32'h21, 32'h1234_56AA, rd, mis, oob, lat, nrdy);
    acc(1'b0, F_W, 32'h20, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h80FF_AA01) begin
      n_fail++; $display("FAIL sb_merge got=%h want=80ffaa01", rd);
    end
    acc(1'b1, F_H, 32'h20, 32'h9999_BEEF, rd, mis, oob, lat, nrdy);
    acc(1'b0, F_W, 32'h20, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h80FF_BEEF) begin
      n_fail++; $display("FAIL sh_merge got=%h want=80ffbeef", rd);
    end
    acc(1'b0, F_H, 32'h20, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'hFFFF_BEEF) begin
      n_fail++; $display("FAIL lh_low got=%h want=ffffbeef", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic mis, oob;
    int lat, nrdy;
    acc(1'b1, F_W, 32'h00, 32'h1122_3344, rd, mis, oob, lat, nrdy);
    acc(1'b0, F_W, 32'h02, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (lat !== 1 || {rd, mis, oob} !== {32'h0, 2'b10}) begin
      n_fail++; $display("FAIL lw_misalign got=%0d %h %b%b want=1 0 10", lat, rd, mis, oob);
    end
    acc(1'b1, F_W, 32'h40, 32'hFFFF_FFFF, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (lat !== 1 || {rd, mis, oob} !== {32'h0, 2'b01}) begin
      n_fail++; $display("FAIL sw_oob got=%0d %h %b%b want=1 0 01", lat, rd, mis, oob);
    end
    acc(1'b1, F_H, 32'h01, 32'h0000_FFFF, rd, mis, oob, lat, nrdy);
    n_chk++;
    if ({mis, oob} !== 2'b10) begin
      n_fail++; $display("FAIL sh_misalign got=%b%b want=10", mis, oob);
    end
    acc(1'b1, F_BU, 32'h00, 32'h0000_00EE, rd, mis, oob, lat, nrdy);
    n_chk++;
    if ({mis, oob} !== 2'b10) begin
      n_fail++; $display("FAIL store_bu got=%b%b want=10", mis, oob);
    end
    acc(1'b0, 3'b011, 32'h00, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if ({rd, mis, oob} !== {32'h0, 2'b10}) begin
      n_fail++; $display("FAIL bad_funct3 got=%h %b%b want=0 10", rd, mis, oob);
    end
    acc(1'b0, F_H, 32'h41, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if ({mis, oob} !== 2'b10) begin
      n_fail++; $display("FAIL mis_priority got=%b%b want=10", mis, oob);
    end
    acc(1'b0, F_W, 32'h00, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if ({rd, mis, oob} !== {32'h1122_3344, 2'b00}) begin
      n_fail++; $display("FAIL err_nowrite got=%h %b%b want=11223344 00", rd, mis, oob);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    z_valid = 1'b1;
    z_we    = 1'b1;
    z_f3    = F_W;
    z_addr  = 32'h30;
    z_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    z_we    = 1'b0;
    z_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_chk++;
    if ({z_rv, z_ready} !== 2'b11 || z_rdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_store got=%b%b %h want=11 0", z_rv, z_ready, z_rdata);
    end
    @(posedge clk);
    #1;
    z_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (z_rv !== 1'b1 || z_rdata !== 32'h0000_0055) begin
      n_fail++; $display("FAIL b2b_load got=%b %h want=1 00000055", z_rv, z_rdata);
    end
    @(negedge clk);
    n_chk++;
    if (z_rv !== 1'b0 || z_rdata !== 32'h0000_0055) begin
      n_fail++; $display("FAIL b2b_idle got=%b %h want=0 00000055", z_rv, z_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic [31:0] want;
    logic mis, oob;
    int lat, nrdy, seen;
`ifdef DMEM_INIT_CLEAR_EN
    want = 32'h0;
`else
    want = 32'hDEAD_BEEF;
`endif
    @(negedge clk);
    a_valid = 1'b1;
    a_we    = 1'b1;
    a_f3    = F_W;
    a_addr  = 32'h10;
    a_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rv) seen++;
    end
    rstn = 1'b1;
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rst_abort_resp got=%0d want=0", seen);
    end
    acc(1'b0, F_W, 32'h10, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== want) begin
      n_fail++; $display("FAIL rst_abort_data got=%h want=%h", rd, want);
    end
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  task automatic test_init();
    logic [31:0] rd;
    logic mis, oob;
    int lat, nrdy;
    acc(1'b1, F_W, 32'h3C, 32'h7777_7777, rd, mis, oob, lat, nrdy);
    test_reset();
    acc(1'b0, F_W, 32'h3C, 32'h0, rd, mis, oob, lat, nrdy);
    n_chk++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL init_clear got=%h want=0", rd);
    end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef DMEM_INIT_CLEAR_EN
    test_init();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
